// File: rtl/shift_seq_if.sv
// Interface for the shift sequencer. It groups the request handshake, the
// shift-unit feed/return path and the result handshake into one bundle.
interface shift_seq_if #(
   parameter int CNT_W = 3
);
   logic             start_valid;
   logic             start_ready;
   logic [7:0]       din;
   logic             cin;
   logic [2:0]       mode;
   logic [CNT_W-1:0] count;
   logic [7:0]       sh_in;
   logic             sh_cin;
   logic [2:0]       sh_mode;
   logic [7:0]       sh_out;
   logic             sh_cout;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       dout;
   logic             cout;

   // The sequencer side.
   modport slave (
      input  start_valid, din, cin, mode, count, sh_out, sh_cout, res_ready,
      output start_ready, sh_in, sh_cin, sh_mode, res_valid, dout, cout
   );

   // The requester, consumer and shift-unit side.
   modport master (
      output start_valid, din, cin, mode, count, sh_out, sh_cout, res_ready,
      input  start_ready, sh_in, sh_cin, sh_mode, res_valid, dout, cout
   );
endinterface

// File: rtl/shift_seq.sv
// Multi-step shift sequencer. It drives an external single-step shift unit
// once per clock and returns the final byte and carry over a valid/ready handshake.
module shift_seq #(
   parameter int CNT_W = 3
) (
   input  logic        clk,
   input  logic        rst,
   shift_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [7:0]       acc_q;
   logic             c_q;
   logic [2:0]       mode_q;
   logic [CNT_W-1:0] rem_q;
   logic             res_valid_q;

   // NOTE: every register here uses non-blocking assignment so that all
   // state updates see the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= 8'h00;
         c_q         <= 1'b0;
         mode_q      <= 3'b000;
         rem_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start_valid) begin
                  acc_q  <= bus.din;
                  c_q    <= bus.cin;
                  mode_q <= bus.mode;
                  rem_q  <= bus.count;
                  if (bus.count != '0) begin
                     state_q <= S_RUN;
                  end else begin
                     state_q     <= S_DONE;
                     res_valid_q <= 1'b1;
                  end
               end
            end

            // Each cycle feeds back one step of the shift unit. The last step
            // happens when rem_q is 1, so rem_q never reaches 0 while in RUN.
            S_RUN: begin
               acc_q <= bus.sh_out;
               c_q   <= bus.sh_cout;
               rem_q <= rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_q     <= S_DONE;
                  res_valid_q <= 1'b1;
               end
            end

            S_DONE: begin
               if (bus.res_ready) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q     <= S_IDLE;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // The gate on rst keeps the sequencer from advertising readiness while
   // it is held in reset.
   assign bus.start_ready = (state_q == S_IDLE) && !rst;
   assign bus.res_valid   = res_valid_q;
   assign bus.dout        = acc_q;
   assign bus.cout        = c_q;
   assign bus.sh_in       = acc_q;
   assign bus.sh_cin      = c_q;
   assign bus.sh_mode     = mode_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed testbench for shift_seq. It includes a behavioural model of the
// external single-step shift unit, and it checks each scenario against
// hand-computed values.
module tb_shift_seq;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   shift_seq_if #(.CNT_W(3)) bus ();

   shift_seq #(.CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External shift unit: one combinational step.
   logic nb;
   always_comb begin
      nb = bus.sh_mode[1] ? (bus.sh_mode[0] ? bus.sh_in[7] : bus.sh_in[0])
                          : (bus.sh_cin & bus.sh_mode[0]);
      if (!bus.sh_mode[2]) begin
         bus.sh_out  = {bus.sh_in[6:0], nb};
         bus.sh_cout = bus.sh_in[7];
      end else begin
         bus.sh_out  = {nb, bus.sh_in[7:1]};
         bus.sh_cout = bus.sh_in[0];
      end
   end

   task automatic accept_op(input logic [7:0] d, input logic c,
                            input logic [2:0] m, input logic [2:0] n);
      @(negedge clk);
      bus.din         = d;
      bus.cin         = c;
      bus.mode        = m;
      bus.count       = n;
      bus.start_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
   endtask

   task automatic take_result();
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      tests_run++;
      if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b0 ||
          bus.dout !== 8'h00 || bus.cout !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: rv=%b sr=%b dout=%h cout=%b, want 0 0 00 0",
                  bus.res_valid, bus.start_ready, bus.dout, bus.cout);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (bus.start_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_idle_ready: start_ready=%b want 1", bus.start_ready);
      end
   endtask

   task automatic test_rol();
      accept_op(8'h81, 1'b0, 3'b011, 3'd3);
      bus.din  = 8'hFF;
      bus.mode = 3'b000;
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (bus.res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rol_latency step %0d: res_valid=%b want 0", k, bus.res_valid);
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.dout !== 8'h0C || bus.cout !== 1'b0) begin
         tests_failed++;
         $display("FAIL rol_result: rv=%b dout=%h cout=%b want 1 0c 0",
                  bus.res_valid, bus.dout, bus.cout);
      end
      take_result();
      tests_run++;
      if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rol_handshake: rv=%b sr=%b want 0 1", bus.res_valid, bus.start_ready);
      end
   endtask

   task automatic test_back_to_back();
      // ASR is accepted right after the previous handshake. It is followed
      // directly by RLC.
      accept_op(8'h90, 1'b0, 3'b111, 3'd2);
      tests_run++;
      if (bus.sh_mode !== 3'b111 || bus.sh_in !== 8'h90 || bus.start_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL asr_feed: sh_mode=%b sh_in=%h sr=%b want 111 90 0",
                  bus.sh_mode, bus.sh_in, bus.start_ready);
      end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.dout !== 8'hE4 || bus.cout !== 1'b0) begin
         tests_failed++;
         $display("FAIL asr_result: rv=%b dout=%h cout=%b want 1 e4 0",
                  bus.res_valid, bus.dout, bus.cout);
      end
      take_result();

      accept_op(8'h80, 1'b0, 3'b001, 3'd2);
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.sh_in !== 8'h00 || bus.sh_cin !== 1'b1 || bus.res_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rlc_intermediate: acc=%h c=%b rv=%b want 00 1 0",
                  bus.sh_in, bus.sh_cin, bus.res_valid);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.dout !== 8'h01 || bus.cout !== 1'b0) begin
         tests_failed++;
         $display("FAIL rlc_result: rv=%b dout=%h cout=%b want 1 01 0",
                  bus.res_valid, bus.dout, bus.cout);
      end
      take_result();
   endtask

   task automatic test_zero_count();
      accept_op(8'h5A, 1'b1, 3'b110, 3'd0);
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.dout !== 8'h5A || bus.cout !== 1'b1) begin
         tests_failed++;
         $display("FAIL zero_count: rv=%b dout=%h cout=%b want 1 5a 1",
                  bus.res_valid, bus.dout, bus.cout);
      end
      take_result();
   endtask

   task automatic test_hold();
      accept_op(8'h3C, 1'b0, 3'b100, 3'd1);
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.din         = 8'hFF;
         bus.count       = 3'd0;
         bus.start_valid = (k % 2 == 0);
         @(posedge clk);
         #1;
         tests_run++;
         if (bus.res_valid !== 1'b1 || bus.dout !== 8'h1E || bus.cout !== 1'b0 ||
             bus.start_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold cycle %0d: rv=%b dout=%h cout=%b sr=%b want 1 1e 0 0",
                     k, bus.res_valid, bus.dout, bus.cout, bus.start_ready);
         end
      end
      bus.start_valid = 1'b0;
      take_result();
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.res_valid !== 1'b0 || bus.dout !== 8'h1E || bus.start_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_not_queued: rv=%b dout=%h sr=%b want 0 1e 1",
                  bus.res_valid, bus.dout, bus.start_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      accept_op(8'h81, 1'b0, 3'b011, 3'd7);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (bus.sh_in !== 8'h0C || bus.res_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_run_acc: acc=%h rv=%b want 0c 0", bus.sh_in, bus.res_valid);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus.dout !== 8'h00 || bus.cout !== 1'b0 || bus.res_valid !== 1'b0 ||
          bus.start_ready !== 1'b0 || bus.sh_mode !== 3'b000) begin
         tests_failed++;
         $display("FAIL mid_run_reset: dout=%h cout=%b rv=%b sr=%b mode=%b want 00 0 0 0 000",
                  bus.dout, bus.cout, bus.res_valid, bus.start_ready, bus.sh_mode);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (bus.start_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_reset_ready: start_ready=%b want 1", bus.start_ready);
      end
      accept_op(8'h01, 1'b1, 3'b000, 3'd7);
      for (int k = 0; k < 7; k++) begin
         tests_run++;
         if (bus.res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lsl7_latency step %0d: res_valid=%b want 0", k, bus.res_valid);
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.dout !== 8'h80 || bus.cout !== 1'b0) begin
         tests_failed++;
         $display("FAIL lsl7_result: rv=%b dout=%h cout=%b want 1 80 0",
                  bus.res_valid, bus.dout, bus.cout);
      end
      take_result();
   endtask

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      rst             = 1'b1;
      bus.start_valid = 1'b0;
      bus.din         = 8'h00;
      bus.cin         = 1'b0;
      bus.mode        = 3'b000;
      bus.count       = 3'd0;
      bus.res_ready   = 1'b0;

      test_reset();
      test_rol();
      test_back_to_back();
      test_zero_count();
      test_hold();
      test_reset_mid_run();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
